spi_xfer_arb: RTL
=================

SPI_XFER_ARB -- requirements
Module: spi_xfer_arb

Interface
REQ-001: Parameter TIMEOUT_CYC, default 4096, is the maximum number of cycles to wait for byte completion before aborting (legal range 2..65535).
REQ-002: pclk  input  1  sole clock, all state on rising edge.
REQ-003: prst  input  1  reset, asynchronous, active-low.
REQ-004: req  input  4  per-requester transfer request, requester i owns chip select i.
REQ-005: tx_data  input  32  TX byte of requester i on bits [8i+7:8i].
REQ-006: tx_last  input  4  bit i high = current byte of requester i is its final byte.
REQ-007: gnt  output  4  one-hot grant, held for the whole transaction.
REQ-008: tx_take  output  1  one-cycle pulse, granted requester's current byte consumed; requester presents next byte on the following cycle.
REQ-009: rx_data  output  8  received byte.
REQ-010: rx_valid  output  1  one-cycle pulse, rx_data valid for granted requester.
REQ-011: done  output  1  one-cycle pulse, transaction completed normally.
REQ-012: err  output  1  one-cycle pulse, transaction aborted on timeout.
REQ-013: busy  output  1  high whenever state is not IDLE.
REQ-014: eng_cmd  output  1  SPI engine command strobe, eng_din[3:0] is a one-hot chip-select mask, 0 deselects all.
REQ-015: eng_wr  output  1  SPI engine byte-write strobe, starts a byte shift.
REQ-016: eng_rd  output  1  SPI engine read strobe.
REQ-017: eng_din  output  8  data/command to engine.
REQ-018: eng_dout  input  8  engine received byte, valid while eng_rd is high.
REQ-019: eng_irq  input  1  engine byte-complete indication.

Function
REQ-020: States are IDLE, SEL, LOAD, WAIT, READ and DESEL; eng_cmd, eng_wr, eng_rd, eng_din and tx_take decode from state and granted index only, with no combinational path from req, eng_irq or eng_dout.
REQ-021: In IDLE with req!=0, round-robin arbitration picks the first set bit searching upward from (last_winner+1) mod 4, with last_winner reset to 3; the winner is registered into gnt and the state moves to SEL on the same edge.
REQ-022: SEL, 1 cycle: eng_cmd=1 with eng_din={4'b0, one-hot(winner)} -> LOAD.
REQ-023: LOAD, 1 cycle: eng_wr=1 with eng_din=winner's tx_data byte and tx_take=1; the state machine latches tx_last[winner], clears the timeout counter and moves to WAIT.
REQ-024: WAIT: the counter increments each cycle; eng_irq=1 -> READ (eng_irq takes precedence over timeout in the same cycle); otherwise counter==TIMEOUT_CYC-1 -> DESEL with the abort flag set.
REQ-025: READ, 1 cycle: eng_rd=1, rx_data<=eng_dout at the end of the cycle and rx_valid=1 in the next cycle; the state moves to DESEL if the latched last flag is set, else to LOAD.
REQ-026: DESEL, 1 cycle: eng_cmd=1 with eng_din=8'h00 -> IDLE; on that edge gnt<=0 and either done<=1 (normal completion) or err<=1 (abort), never both.
REQ-027: The minimum single-byte transaction, with eng_irq present on the first WAIT cycle, takes req to gnt 1 cycle and gnt to done 5 cycles.
REQ-028: req is sampled only in IDLE; deasserting req mid-transaction is ignored, and the transaction ends only via the last byte or timeout.
REQ-029: An aborted byte produces no rx_valid.
REQ-030: A requester still requesting after its own done is re-granted only if no other req bit is set (fairness).
REQ-031: eng_irq is ignored outside WAIT.
REQ-032: The timeout counter is 16 bits wide and does not wrap.

Reset
REQ-033: While prst=0, all state is asynchronously forced to IDLE: gnt=0, tx_take=0, rx_data=8'h00, rx_valid=0, done=0, err=0, busy=0, eng_cmd=0, eng_wr=0, eng_rd=0, eng_din=8'h00, counter=0 and last_winner=3.
REQ-034: Reset mid-transaction drops all strobes immediately with no deselect command issued; the engine is reset from the same prst.
REQ-035: The first arbitration after reset release starts at requester 0.

Verification
REQ-036: req=4'b0001, tx_data[7:0]=8'hA5, tx_last[0]=1, engine echoes 8'h3C with eng_irq 3 cycles after eng_wr -> the bench must see eng_cmd din=8'h01, then eng_wr din=8'hA5, then rx_data=8'h3C with rx_valid, then eng_cmd din=8'h00, then done with gnt back to 0.
REQ-037: req=4'b1111 held with single-byte transfers -> the grant order must be 0,1,2,3,0 and each gnt must be one-hot.
REQ-038: Requester 2 sends 3 bytes 11,22,33 with tx_last set on 33 -> the bench must see three eng_wr, three tx_take, three rx_valid, and exactly one SEL and one DESEL.
REQ-039: TIMEOUT_CYC=8 with no eng_irq -> the bench must see DESEL after 8 WAIT cycles, err=1, done=0 and no rx_valid.
REQ-040: eng_irq and counter==TIMEOUT_CYC-1 in the same cycle -> the state must go to READ with no error.
REQ-041: prst pulled low during WAIT of a 2-byte transfer -> all outputs must be 0 the same cycle, and after release req=4'b0100 must be granted normally.

Source files
------------

// File: rtl/spi_xfer_arb.sv
// spi_xfer_arb: round-robin arbiter that sequences the byte transfers of four requesters through one SPI engine
module spi_xfer_arb #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic [3:0]  req,
    input  logic [31:0] tx_data,
    input  logic [3:0]  tx_last,
    output logic [3:0]  gnt,
    output logic        tx_take,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        eng_cmd,
    output logic        eng_wr,
    output logic        eng_rd,
    output logic [7:0]  eng_din,
    input  logic [7:0]  eng_dout,
    input  logic        eng_irq
);
    typedef enum logic [2:0] {IDLE, SEL, LOAD, WAIT, READ, DESEL} state_t;
    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  last_w;
    logic [1:0]  win;
    logic [15:0] cnt;
    logic        last;
    logic        abort;
    // scan downward so the nearest requester after last_w is the final assignment
    always_comb begin
        win = last_w;
        for (int k = 4; k >= 1; k--)
            if (req[last_w + 2'(k)]) win = last_w + 2'(k);
    end
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state    <= IDLE;
            gnt      <= '0;
            idx      <= '0;
            last_w   <= 2'd3;
            cnt      <= '0;
            last     <= 1'b0;
            abort    <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    gnt    <= 4'b0001 << win;
                    idx    <= win;
                    last_w <= win;
                    state  <= SEL;
                end
                SEL: begin
                    abort <= 1'b0;
                    state <= LOAD;
                end
                LOAD: begin
                    last  <= tx_last[idx];
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    if (eng_irq) state <= READ;
                    else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
                        abort <= 1'b1;
                        state <= DESEL;
                    end
                end
                READ: begin
                    rx_data  <= eng_dout;
                    rx_valid <= 1'b1;
                    state    <= last ? DESEL : LOAD;
                end
                DESEL: begin
                    gnt   <= '0;
                    done  <= !abort;
                    err   <= abort;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy    = state != IDLE;
    assign eng_cmd = state == SEL || state == DESEL;
    assign eng_wr  = state == LOAD;
    assign eng_rd  = state == READ;
    assign tx_take = state == LOAD;
    assign eng_din = state == SEL ? {4'b0000, gnt} : eng_wr ? tx_data[{idx, 3'b000} +: 8] : 8'h00;
endmodule
